// File: rtl/spi_slave_core_pkg.sv
// Shared SPI slave definitions: word-width codes, data width and FSM states.
package spi_slave_core_pkg;

    localparam int SPI_DATA_WIDTH = 32;

    localparam logic [1:0] SPI_TRANS_8_BITS  = 2'd0;
    localparam logic [1:0] SPI_TRANS_16_BITS = 2'd1;
    localparam logic [1:0] SPI_TRANS_24_BITS = 2'd2;
    localparam logic [1:0] SPI_TRANS_32_BITS = 2'd3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slave_state_e;

    // Word length in bits, 8 * (code + 1).
    function automatic logic [5:0] word_bits(input logic [1:0] dtb);
        logic [2:0] bytes;
        bytes = {1'b0, dtb} + 3'd1;
        return {bytes, 3'b000};
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer for one asynchronous input with a selectable reset level.
module spi_slave_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spi_slave_core.sv
// SPI target engine: oversamples SCK/NSS/MOSI, shifts 8..32-bit words, and
// exchanges them with a local valid/ready interface.
module spi_slave_core
    import spi_slave_core_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_i,
    input  logic [1:0]            dtb_i,
    input  logic                  spi_sck_i,
    input  logic                  spi_nss_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_en_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  rx_valid_o,
    input  logic                  rx_ready_i,
    output logic                  rx_ovf_o,
    output logic                  tx_udf_o,
    output logic                  busy_o
);

    logic sck_s, nss_s, mosi_s, sck_d;
    logic rise_p1, fall_p1, mosi_p1, nss_p1;
    logic [2:0] settle;

    spi_slave_state_e state;
    logic cpol_l, cpha_l, lsb_l, armed, skip, udf_pend, hold_full;
    logic [5:0] nbits;
    logic [4:0] cnt;
    logic [DATA_WIDTH-1:0] tx_shift, rx_shift, rx_next, hold_data;
    logic leading, trailing, sample, drive, accept, last_bit;

    function automatic logic [DATA_WIDTH-1:0] align_tx(input logic [DATA_WIDTH-1:0] w,
                                                      input logic [5:0] n, input logic lsb);
        return lsb ? w : (w << (6'(DATA_WIDTH) - n));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extract_rx(input logic [DATA_WIDTH-1:0] s,
                                                        input logic [5:0] n, input logic lsb);
        logic [DATA_WIDTH-1:0] mask;
        mask = ~({DATA_WIDTH{1'b1}} << n);
        return lsb ? (s >> (6'(DATA_WIDTH) - n)) : (s & mask);
    endfunction

    spi_slave_sync #(.RST_VAL(1'b0)) u_sync_sck  (.clk(clk_i), .rst(rst_i), .d(spi_sck_i),  .q(sck_s));
    spi_slave_sync #(.RST_VAL(1'b1)) u_sync_nss  (.clk(clk_i), .rst(rst_i), .d(spi_nss_i),  .q(nss_s));
    spi_slave_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk_i), .rst(rst_i), .d(spi_mosi_i), .q(mosi_s));

    // Stage p1: registered edge pulses, aligned MOSI/NSS samples
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_d   <= 1'b0;
            rise_p1 <= 1'b0;
            fall_p1 <= 1'b0;
            mosi_p1 <= 1'b0;
            nss_p1  <= 1'b1;
            settle  <= 3'b000;
        end else begin
            sck_d   <= sck_s;
            rise_p1 <= sck_s & ~sck_d;
            fall_p1 <= ~sck_s & sck_d;
            mosi_p1 <= mosi_s;
            nss_p1  <= nss_s;
            settle  <= {settle[1:0], 1'b1};
        end
    end

    assign leading  = cpol_l ? fall_p1 : rise_p1;
    assign trailing = cpol_l ? rise_p1 : fall_p1;
    assign sample   = cpha_l ? trailing : leading;
    assign drive    = cpha_l ? leading : trailing;
    assign accept   = tx_valid_i & ~hold_full;
    assign last_bit = ({1'b0, cnt} == nbits - 6'd1);
    assign rx_next  = lsb_l ? {mosi_p1, rx_shift[DATA_WIDTH-1:1]}
                            : {rx_shift[DATA_WIDTH-2:0], mosi_p1};

    assign tx_ready_o    = ~hold_full;
    assign spi_miso_o    = lsb_l ? tx_shift[0] : tx_shift[DATA_WIDTH-1];
    assign busy_o        = ~nss_s;
    assign spi_miso_en_o = ~nss_s;

    always_ff @(posedge clk_i) begin
        if (accept) hold_data <= tx_data_i;
    end

    // Stage p2: frame FSM, shifters and handshakes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            armed      <= 1'b0;
            cpol_l     <= 1'b0;
            cpha_l     <= 1'b0;
            lsb_l      <= 1'b0;
            nbits      <= 6'd8;
            cnt        <= '0;
            skip       <= 1'b0;
            udf_pend   <= 1'b0;
            hold_full  <= 1'b0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            rx_ovf_o   <= 1'b0;
            tx_udf_o   <= 1'b0;
        end else begin
            rx_ovf_o <= 1'b0;
            tx_udf_o <= 1'b0;
            if (accept) hold_full <= 1'b1;
            if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    // Only a high NSS seen after the reset values have flushed arms a new frame.
                    if (nss_p1) begin
                        armed <= settle[2];
                    end else if (armed) begin
                        state    <= ACTIVE;
                        armed    <= 1'b0;
                        cpol_l   <= cpol_i;
                        cpha_l   <= cpha_i;
                        lsb_l    <= lsb_i;
                        nbits    <= word_bits(dtb_i);
                        cnt      <= '0;
                        rx_shift <= '0;
                        skip     <= cpha_i;
                        udf_pend <= 1'b0;
                        if (hold_full) begin
                            tx_shift  <= align_tx(hold_data, word_bits(dtb_i), lsb_i);
                            hold_full <= 1'b0;
                        end else begin
                            tx_shift <= '0;
                            tx_udf_o <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (nss_p1) begin
                        state    <= IDLE;
                        armed    <= 1'b1;
                        cnt      <= '0;
                        tx_shift <= '0;
                        skip     <= 1'b0;
                        udf_pend <= 1'b0;
                    end else begin
                        if (drive) begin
                            if (skip) skip <= 1'b0;
                            else      tx_shift <= lsb_l ? (tx_shift >> 1) : (tx_shift << 1);
                        end
                        if (sample) begin
                            rx_shift <= rx_next;
                            if (udf_pend) begin
                                tx_udf_o <= 1'b1;
                                udf_pend <= 1'b0;
                            end
                            if (last_bit) begin
                                cnt        <= '0;
                                rx_data_o  <= extract_rx(rx_next, nbits, lsb_l);
                                rx_valid_o <= 1'b1;
                                rx_ovf_o   <= rx_valid_o & ~rx_ready_i;
                                // The next drive edge belongs to the finished word; it must not shift.
                                skip       <= 1'b1;
                                if (hold_full) begin
                                    tx_shift  <= align_tx(hold_data, nbits, lsb_l);
                                    hold_full <= 1'b0;
                                    udf_pend  <= 1'b0;
                                end else begin
                                    // Underflow is reported only if the master actually starts this word.
                                    tx_shift  <= '0;
                                    udf_pend  <= 1'b1;
                                end
                            end else begin
                                cnt <= cnt + 5'd1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: a bit-banged SPI master plus table-driven frames.
module tb_spi_slave_core;
    import spi_slave_core_pkg::*;

    localparam int HALF = 4;

    logic        clk = 1'b0;
    logic        rst, cpol, cpha, lsb;
    logic [1:0]  dtb;
    logic        sck, nss, mosi, miso, miso_en;
    logic [31:0] tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, rx_ovf, tx_udf, busy;

    int checks = 0;
    int errors = 0;
    int udf_cnt = 0;
    int ovf_cnt = 0;
    logic [31:0] rxq[$];

    spi_slave_core dut (
        .clk_i(clk), .rst_i(rst), .cpol_i(cpol), .cpha_i(cpha), .lsb_i(lsb), .dtb_i(dtb),
        .spi_sck_i(sck), .spi_nss_i(nss), .spi_mosi_i(mosi),
        .spi_miso_o(miso), .spi_miso_en_o(miso_en),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
        .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
        .rx_ovf_o(rx_ovf), .tx_udf_o(tx_udf), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_udf) udf_cnt++;
        if (rx_ovf) ovf_cnt++;
        if (rx_valid && rx_ready) rxq.push_back(rx_data);
    end

    typedef struct {
        logic        cpol, cpha, lsb;
        logic [1:0]  dtb;
        logic        has_tx;
        logic [31:0] tx, mo, exp_mi, exp_rx;
        int          exp_udf;
    } vec_t;

    vec_t vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] last_rx();
        if (rxq.size() == 0) return 32'hxxxx_xxxx;
        return rxq[rxq.size()-1];
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(6);
    endtask

    task automatic set_mode(input logic p, input logic h, input logic l, input logic [1:0] d);
        cpol = p; cpha = h; lsb = l; dtb = d; sck = p;
        tick(4);
    endtask

    task automatic push_tx(input logic [31:0] d);
        int k = 0;
        while (!tx_ready && k < 50) begin
            tick(1);
            k++;
        end
        if (!tx_ready) check("tx_ready_timeout", tx_ready, 1'b1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
    endtask

    task automatic open_frame();
        nss = 1'b0;
        tick(8);
    endtask

    task automatic close_frame();
        tick(HALF);
        nss = 1'b1;
        tick(8);
    endtask

    task automatic xfer(input logic [31:0] mo, input int nbits, output logic [31:0] mi);
        int n = 8 * (int'(dtb) + 1);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx = lsb ? i : n - 1 - i;
            if (!cpha) begin
                mosi = mo[idx];
                tick(HALF);
                sck = ~cpol;
                mi[idx] = miso;
                tick(HALF);
                sck = cpol;
            end else begin
                sck = ~cpol;
                mosi = mo[idx];
                tick(HALF);
                sck = cpol;
                mi[idx] = miso;
                tick(HALF);
            end
        end
    endtask

    initial begin
        logic [31:0] mi, mi2;
        int u0, n0, o0;

        rst = 1'b1; cpol = 0; cpha = 0; lsb = 0; dtb = SPI_TRANS_8_BITS;
        sck = 0; nss = 1; mosi = 0; tx_data = '0; tx_valid = 0; rx_ready = 1;
        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_miso", miso, 0);
        check("rst_miso_en", miso_en, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_ovf", rx_ovf, 0);
        check("rst_tx_udf", tx_udf, 0);
        check("rst_busy", busy, 0);

        //        cpol cpha lsb dtb                has_tx tx            mosi          exp miso      exp rx        udf
        vt[0] = '{1'b0, 1'b0, 1'b0, SPI_TRANS_8_BITS,  1'b1, 32'hA5,       32'h3C,       32'hA5,       32'h3C,       0};
        vt[1] = '{1'b0, 1'b1, 1'b0, SPI_TRANS_16_BITS, 1'b0, 32'h0,        32'h1234,     32'h0000,     32'h1234,     1};
        vt[2] = '{1'b1, 1'b0, 1'b1, SPI_TRANS_24_BITS, 1'b1, 32'hABCDEF,   32'h5A5A5A,   32'hABCDEF,   32'h5A5A5A,   0};
        vt[3] = '{1'b1, 1'b1, 1'b0, SPI_TRANS_16_BITS, 1'b1, 32'hBEEF,     32'hC0DE,     32'hBEEF,     32'hC0DE,     0};
        vt[4] = '{1'b0, 1'b0, 1'b1, SPI_TRANS_32_BITS, 1'b1, 32'h80000001, 32'hCAFEF00D, 32'h80000001, 32'hCAFEF00D, 0};
        vt[5] = '{1'b1, 1'b0, 1'b0, SPI_TRANS_8_BITS,  1'b1, 32'h1C3,      32'h81,       32'hC3,       32'h81,       0};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            set_mode(vt[v].cpol, vt[v].cpha, vt[v].lsb, vt[v].dtb);
            rx_ready = 1'b1;
            if (vt[v].has_tx) push_tx(vt[v].tx);
            u0 = udf_cnt;
            n0 = rxq.size();
            open_frame();
            check($sformatf("v%0d_busy", v), busy, 1);
            xfer(vt[v].mo, 8 * (int'(vt[v].dtb) + 1), mi);
            close_frame();
            check($sformatf("v%0d_master_rx", v), mi, vt[v].exp_mi);
            check($sformatf("v%0d_rx_count", v), rxq.size() - n0, 1);
            check($sformatf("v%0d_rx_data", v), last_rx(), vt[v].exp_rx);
            check($sformatf("v%0d_udf", v), udf_cnt - u0, vt[v].exp_udf);
        end

        // Mode 3, LSB-first, two back-to-back 32-bit words
        do_reset();
        set_mode(1'b1, 1'b1, 1'b1, SPI_TRANS_32_BITS);
        rx_ready = 1'b1;
        push_tx(32'h12345678);
        check("b2b_ready_after_accept", tx_ready, 0);
        u0 = udf_cnt;
        n0 = rxq.size();
        open_frame();
        check("b2b_ready_after_load", tx_ready, 1);
        push_tx(32'hDEADBEEF);
        xfer(32'hA1B2C3D4, 32, mi);
        xfer(32'h0F1E2D3C, 32, mi2);
        close_frame();
        check("b2b_master_w0", mi, 32'h12345678);
        check("b2b_master_w1", mi2, 32'hDEADBEEF);
        check("b2b_rx_count", rxq.size() - n0, 2);
        check("b2b_rx_w0", (rxq.size() >= 2) ? rxq[rxq.size()-2] : 32'hxxxx_xxxx, 32'hA1B2C3D4);
        check("b2b_rx_w1", last_rx(), 32'h0F1E2D3C);
        check("b2b_udf", udf_cnt - u0, 0);

        // Two unread 8-bit words: overwrite and overflow pulse
        do_reset();
        set_mode(1'b0, 1'b0, 1'b0, SPI_TRANS_8_BITS);
        rx_ready = 1'b0;
        push_tx(32'h55);
        o0 = ovf_cnt;
        open_frame();
        xfer(32'h11, 8, mi);
        xfer(32'h22, 8, mi2);
        close_frame();
        check("ovf_rx_data", rx_data, 32'h22);
        check("ovf_rx_valid", rx_valid, 1);
        check("ovf_pulses", ovf_cnt - o0, 1);
        rx_ready = 1'b1;
        tick(2);
        check("ovf_rx_valid_cleared", rx_valid, 0);

        // NSS rise after 5 bits, then a full frame
        do_reset();
        set_mode(1'b0, 1'b0, 1'b0, SPI_TRANS_8_BITS);
        rx_ready = 1'b1;
        n0 = rxq.size();
        open_frame();
        xfer(32'hFF, 5, mi);
        close_frame();
        check("partial_rx_count", rxq.size() - n0, 0);
        check("partial_rx_valid", rx_valid, 0);
        check("partial_rx_data_kept", rx_data, 0);
        push_tx(32'h99);
        open_frame();
        xfer(32'h7E, 8, mi);
        close_frame();
        check("after_partial_rx", last_rx(), 32'h7E);
        check("after_partial_master", mi, 32'h99);

        // Reset asserted mid-word, then a normal frame
        do_reset();
        set_mode(1'b0, 1'b0, 1'b0, SPI_TRANS_8_BITS);
        rx_ready = 1'b1;
        push_tx(32'h66);
        open_frame();
        xfer(32'hF0, 4, mi);
        rst = 1'b1;
        tick(1);
        check("midrst_miso", miso, 0);
        check("midrst_miso_en", miso_en, 0);
        check("midrst_tx_ready", tx_ready, 1);
        check("midrst_rx_data", rx_data, 0);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        tick(4);
        nss = 1'b1;
        tick(8);
        n0 = rxq.size();
        push_tx(32'h3A);
        open_frame();
        xfer(32'hC5, 8, mi);
        close_frame();
        check("postrst_master", mi, 32'h3A);
        check("postrst_rx_count", rxq.size() - n0, 1);
        check("postrst_rx", last_rx(), 32'hC5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
